ad9228_serializer: RTL
======================

AD9228_SERIALIZER -- requirements
Module: AD9228_serializer

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 12, meaning sample width in bits; must be even and at least 4.
REQ-002 SHALL have parameter DIN_INVERTED, default 0, meaning din is driven inverted when 1.
REQ-003 SHALL have parameter DCO_INVERTED, default 0, meaning dco is driven inverted when 1.
REQ-004 SHALL have parameter FCO_INVERTED, default 0, meaning fco is driven inverted when 1.
REQ-005 SHALL have port clk  input  1  bit-rate clock, one serial bit per rising edge; the design uses this single clock only.
REQ-006 SHALL have port rstn  input  1  reset, asynchronous and active-low.
REQ-007 SHALL have port enable  input  1  serial transmission enable.
REQ-008 SHALL have port pattern_sel  input  2  source select: 0 stream, 1 ramp, 2 checkerboard, 3 all-zero.
REQ-009 SHALL have port s_data  input  DATA_WIDTH  parallel sample to transmit.
REQ-010 SHALL have port s_valid  input  1  s_data is valid.
REQ-011 SHALL have port s_ready  output  1  block accepts s_data this cycle.
REQ-012 SHALL have port din  output  1  serial data, MSB first.
REQ-013 SHALL have port dco  output  1  bit clock, two bits per period (DDR).
REQ-014 SHALL have port fco  output  1  frame clock, one period per sample.
REQ-015 SHALL have port frame_start  output  1  one-cycle pulse coincident with bit index 0 on din.
REQ-016 SHALL have port underrun  output  1  sticky flag: a stream frame started with no new sample.

Function
REQ-017 SHALL keep a bit index i counting 0..DATA_WIDTH-1, advancing once per clk while transmitting and wrapping from DATA_WIDTH-1 to 0.
REQ-018 SHALL register every serial output; in the cycle showing bit index i, pre-inversion values: din = word bit (DATA_WIDTH-1-i), fco = 1 for i < DATA_WIDTH/2 else 0, dco = 1 for even i else 0.
REQ-019 SHALL apply each *_INVERTED parameter as a final XOR on the registered output only.
REQ-020 SHALL load the frame word into the shift register at i = 0, from the source selected by pattern_sel sampled at that same edge; pattern_sel changes never take effect mid-frame.
REQ-021 SHALL hold one stream sample in a one-entry holding register; accept s_data when s_valid && s_ready.
REQ-022 SHALL drive s_ready = 1 when pattern_sel = 0 and (the holding register is empty or is being consumed at this edge); otherwise 0.
REQ-023 SHALL, at a stream frame start with the holding register empty, retransmit the previous frame word and set underrun; underrun clears only on reset.
REQ-024 SHALL increment the ramp value by 1 per ramp frame, starting at 0 after reset, wrapping from 2^DATA_WIDTH-1 to 0.
REQ-025 SHALL use checkerboard word 1010...10 (MSB = 1); all-zero word is 0.
REQ-026 SHALL, when enable rises while idle, present bit index 0 of the first frame on outputs one clk later.
REQ-027 SHALL, when enable falls mid-frame, complete the current frame, then go idle with din, dco, fco pre-inversion 0 and frame_start 0.
REQ-028 SHALL retain the holding register contents across idle periods.
REQ-029 SHALL have two states, IDLE and SHIFT: IDLE->SHIFT on enable; SHIFT->IDLE at i = DATA_WIDTH-1 with enable low.

Reset
REQ-030 SHALL, while rstn is low, force pre-inversion din, dco, fco to 0; frame_start, underrun, s_ready, ramp value, holding register, bit index and previous word to 0; state IDLE.
REQ-031 SHALL take effect asynchronously on reset assertion mid-frame and resume only via IDLE after release.

Verification
REQ-032 SHALL test stream: s_data 0xABC accepted, enable=1 -> din 1,0,1,0,1,0,1,1,1,1,0,0; fco 1 for 6 clk then 0 for 6; dco toggles every clk.
REQ-033 SHALL test ramp: pattern_sel=1 for 4 frames -> words 0x000, 0x001, 0x002, 0x003; DATA_WIDTH=4 run wraps 0xF->0x0.
REQ-034 SHALL test underrun: one sample 0x123, then s_valid low -> second frame retransmits 0x123, underrun=1 from that frame until reset.
REQ-035 SHALL test enable drop at i=5 -> frame completes through i=11, then outputs 0 and frame_start stays 0.
REQ-036 SHALL test inversion: all *_INVERTED=1, reset held -> din=dco=fco=1; checkerboard frame -> din 0,1,0,1...
REQ-037 SHALL test reset at i=7 -> outputs reset immediately; after release with enable=1, first frame_start exactly one clk later, underrun 0.

Source files
------------

// File: rtl/ad9228_serializer.sv
// ad9228_serializer: emulates the serial LVDS output of an AD9228-style ADC.
// One sample word is shifted out MSB first per frame, accompanied by a DDR
// bit clock (dco) and a frame clock (fco). The word comes from a one-entry
// stream holding register or from one of three built-in test patterns.
// DATA_WIDTH must be even and at least 4.
module ad9228_serializer #(
  parameter int DATA_WIDTH   = 12,
  parameter int DIN_INVERTED = 0,
  parameter int DCO_INVERTED = 0,
  parameter int FCO_INVERTED = 0
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  enable,
  input  logic [1:0]            pattern_sel,
  input  logic [DATA_WIDTH-1:0] s_data,
  input  logic                  s_valid,
  output logic                  s_ready,
  output logic                  din,
  output logic                  dco,
  output logic                  fco,
  output logic                  frame_start,
  output logic                  underrun
);

  localparam int                IDX_W    = $clog2(DATA_WIDTH);
  localparam logic [IDX_W-1:0]  IDX_LAST = IDX_W'(DATA_WIDTH - 1);
  localparam logic [IDX_W-1:0]  IDX_HALF = IDX_W'(DATA_WIDTH / 2);
  localparam logic [DATA_WIDTH-1:0] CHECKER_WORD = {(DATA_WIDTH / 2){2'b10}};

  localparam logic DIN_INV = (DIN_INVERTED != 0);
  localparam logic DCO_INV = (DCO_INVERTED != 0);
  localparam logic FCO_INV = (FCO_INVERTED != 0);

  localparam logic [1:0] SEL_STREAM  = 2'd0;
  localparam logic [1:0] SEL_RAMP    = 2'd1;
  localparam logic [1:0] SEL_CHECKER = 2'd2;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t                state_q, state_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic [DATA_WIDTH-1:0] shreg_q, shreg_d;
  logic [DATA_WIDTH-1:0] prev_word_q, prev_word_d;
  logic [DATA_WIDTH-1:0] hold_q, hold_d;
  logic                  hold_valid_q, hold_valid_d;
  logic [DATA_WIDTH-1:0] ramp_q, ramp_d;
  logic                  din_q, din_d;
  logic                  dco_q, dco_d;
  logic                  fco_q, fco_d;
  logic                  frame_start_q, frame_start_d;
  logic                  underrun_q, underrun_d;

  logic                  load;
  logic                  consume;
  logic                  ready_c;
  logic [DATA_WIDTH-1:0] frame_word;

  // Frame sequencing: next state, bit index, shift register and registered outputs.
  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned,
    // which would otherwise infer a latch.
    state_d       = state_q;
    idx_d         = idx_q;
    shreg_d       = shreg_q;
    prev_word_d   = prev_word_q;
    ramp_d        = ramp_q;
    underrun_d    = underrun_q;
    din_d         = 1'b0;
    dco_d         = 1'b0;
    fco_d         = 1'b0;
    frame_start_d = 1'b0;
    load          = 1'b0;
    consume       = 1'b0;
    frame_word    = prev_word_q;

    unique case (state_q)
      IDLE: begin
        if (enable) begin
          state_d = SHIFT;
          load    = 1'b1;
        end
      end
      SHIFT: begin
        if (idx_q == IDX_LAST) begin
          // Enable is only looked at on frame boundaries, so a drop mid-frame
          // lets the current word finish.
          if (enable) begin
            load = 1'b1;
          end else begin
            state_d = IDLE;
            idx_d   = '0;
          end
        end else begin
          idx_d   = idx_q + IDX_W'(1);
          din_d   = shreg_q[DATA_WIDTH-1];
          shreg_d = shreg_q << 1;
        end
      end
      default: state_d = IDLE;
    endcase

    // Word source is chosen only here, at bit 0, so pattern_sel changes
    // never corrupt a frame in flight.
    if (load) begin
      idx_d = '0;
      unique case (pattern_sel)
        SEL_STREAM: begin
          if (hold_valid_q) begin
            frame_word = hold_q;
            consume    = 1'b1;
          end else begin
            underrun_d = 1'b1;
          end
        end
        SEL_RAMP: begin
          frame_word = ramp_q;
          ramp_d     = ramp_q + DATA_WIDTH'(1);
        end
        SEL_CHECKER: frame_word = CHECKER_WORD;
        default:     frame_word = '0;
      endcase
      prev_word_d   = frame_word;
      din_d         = frame_word[DATA_WIDTH-1];
      shreg_d       = frame_word << 1;
      frame_start_d = 1'b1;
    end

    if (state_d == SHIFT) begin
      dco_d = ~idx_d[0];
      fco_d = (idx_d < IDX_HALF);
    end
  end

  // One-entry stream holding register; a word can be accepted on the same
  // edge the previous one is consumed into a frame.
  always_comb begin
    ready_c      = (pattern_sel == SEL_STREAM) && (!hold_valid_q || consume);
    hold_d       = hold_q;
    hold_valid_d = hold_valid_q;
    if (consume) begin
      hold_valid_d = 1'b0;
    end
    if (s_valid && ready_c) begin
      hold_d       = s_data;
      hold_valid_d = 1'b1;
    end
  end

  // State and datapath registers, all cleared by the asynchronous reset.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      // NOTE: the holding register is a plain data flop, but it is reset here
      // because stale sample data must never appear after a reset.
      state_q       <= IDLE;
      idx_q         <= '0;
      shreg_q       <= '0;
      prev_word_q   <= '0;
      hold_q        <= '0;
      hold_valid_q  <= 1'b0;
      ramp_q        <= '0;
      din_q         <= 1'b0;
      dco_q         <= 1'b0;
      fco_q         <= 1'b0;
      frame_start_q <= 1'b0;
      underrun_q    <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      state_q       <= state_d;
      idx_q         <= idx_d;
      shreg_q       <= shreg_d;
      prev_word_q   <= prev_word_d;
      hold_q        <= hold_d;
      hold_valid_q  <= hold_valid_d;
      ramp_q        <= ramp_d;
      din_q         <= din_d;
      dco_q         <= dco_d;
      fco_q         <= fco_d;
      frame_start_q <= frame_start_d;
      underrun_q    <= underrun_d;
    end
  end

  // Ready is combinational from the hold state, gated off while in reset.
  assign s_ready     = ready_c & rstn;
  assign din         = din_q ^ DIN_INV;
  assign dco         = dco_q ^ DCO_INV;
  assign fco         = fco_q ^ FCO_INV;
  assign frame_start = frame_start_q;
  assign underrun    = underrun_q;

endmodule
